// File: rtl/lock_pkg.sv
// Shared definitions for the encoded lock machine: controller state encoding,
// default code geometry (also used by the LFSR bench) and a width helper.
package lock_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CAPTURE  = 3'd1,
    LOCKED_S = 3'd2,
    CHECK    = 3'd3,
    LOCKOUT  = 3'd4
  } lock_state_t;

  localparam int DEF_WIDTH  = 5;
  localparam int DEF_DIGITS = 4;

  // Ceiling log2, never below 1 so it can size a counter directly.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/code_store.sv
// DIGITS x WIDTH register file holding the captured secret code.
// One synchronous write port, one combinational read port.
module code_store
  import lock_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS,
  parameter int IW     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IW-1:0]    widx,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IW-1:0]    ridx,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DIGITS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DIGITS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  // Indices past DIGITS only occur when the reader does not care; return zero.
  assign rdata = ({1'b0, ridx} < (IW + 1)'(DIGITS)) ? mem[ridx] : '0;

endmodule

// File: rtl/code_lock_ctrl.sv
// Code lock controller: captures DIGITS LFSR outputs as the secret, checks
// full key sequences against it, and locks out after MAX_FAILS failures.
module code_lock_ctrl
  import lock_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int DIGITS         = DEF_DIGITS,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 8,
  localparam int FW = clog2(MAX_FAILS + 1),
  localparam int EW = clog2(DIGITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] lfsr_q,
  input  logic             arm,
  input  logic [WIDTH-1:0] key,
  input  logic             key_valid,
  input  logic             clear,
  output logic             locked,
  output logic             open,
  output logic             alarm,
  output logic             err,
  output logic [FW-1:0]    fail_cnt,
  output logic [EW-1:0]    entry_cnt,
  output lock_state_t      dbg_state
);

  localparam int IW = clog2(DIGITS);
  localparam int TW = clog2(LOCKOUT_CYCLES + 1);

  lock_state_t      state;
  logic [IW-1:0]    cap_idx;
  logic [TW-1:0]    timer;
  logic             mismatch;
  logic [WIDTH-1:0] code_digit;
  logic             key_miss;

  code_store #(.WIDTH(WIDTH), .DIGITS(DIGITS), .IW(IW)) u_code_store (
    .clk   (clk),
    .rst   (rst),
    .we    (state == CAPTURE),
    .widx  (cap_idx),
    .wdata (lfsr_q),
    .ridx  (entry_cnt[IW-1:0]),
    .rdata (code_digit)
  );

  // Accumulated mismatch including the key arriving this cycle.
  assign key_miss  = mismatch | (key != code_digit);
  assign dbg_state = state;

  // The verdict (err, fail_cnt) is registered on the edge into CHECK so that
  // it is visible for exactly the one CHECK cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      open      <= 1'b1;
      locked    <= 1'b0;
      alarm     <= 1'b0;
      err       <= 1'b0;
      fail_cnt  <= '0;
      entry_cnt <= '0;
      mismatch  <= 1'b0;
      cap_idx   <= '0;
      timer     <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (arm) begin
            state   <= CAPTURE;
            cap_idx <= '0;
            open    <= 1'b0;
            locked  <= 1'b1;
          end
        end
        CAPTURE: begin
          cap_idx <= cap_idx + IW'(1);
          if (cap_idx == IW'(DIGITS - 1)) state <= LOCKED_S;
        end
        LOCKED_S: begin
          if (clear) begin
            entry_cnt <= '0;
            mismatch  <= 1'b0;
          end else if (key_valid) begin
            entry_cnt <= entry_cnt + EW'(1);
            mismatch  <= key_miss;
            if (entry_cnt == EW'(DIGITS - 1)) begin
              state    <= CHECK;
              err      <= key_miss;
              fail_cnt <= key_miss ? fail_cnt + FW'(1) : '0;
            end
          end
        end
        CHECK: begin
          entry_cnt <= '0;
          mismatch  <= 1'b0;
          if (!mismatch) begin
            state  <= IDLE;
            open   <= 1'b1;
            locked <= 1'b0;
          end else if (fail_cnt == FW'(MAX_FAILS)) begin
            state <= LOCKOUT;
            alarm <= 1'b1;
            timer <= TW'(LOCKOUT_CYCLES);
          end else begin
            state <= LOCKED_S;
          end
        end
        LOCKOUT: begin
          if (timer == TW'(1)) begin
            state     <= LOCKED_S;
            alarm     <= 1'b0;
            fail_cnt  <= '0;
            entry_cnt <= '0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          open      <= 1'b1;
          locked    <= 1'b0;
          alarm     <= 1'b0;
          fail_cnt  <= '0;
          entry_cnt <= '0;
          mismatch  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/code_lock_ctrl.md
Name: code_lock_ctrl

Overview:
- Lock controller directly downstream of the 5-bit LFSR in the encoded lock machine.
- On arm, snapshots DIGITS consecutive LFSR outputs as the secret code.
- Then accepts user key entries, compares the full sequence against the code, and opens, re-locks, or enters a timed lockout after repeated failures.

Parameters:
- WIDTH, 5, bit width of one code digit; matches LFSR q width.
- DIGITS, 4, number of digits in the code and in each entry attempt (>=1).
- MAX_FAILS, 3, consecutive failed attempts that trigger lockout (>=1).
- LOCKOUT_CYCLES, 8, clock cycles spent in lockout (>=1).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- LFSR_Q  in  WIDTH  current LFSR output; sampled only in CAPTURE.
- ARM  in  1  level; sampled in IDLE only; starts capture.
- KEY  in  WIDTH  entered digit; qualified by KEY_VALID.
- KEY_VALID  in  1  one-cycle strobe per entered digit.
- CLEAR  in  1  discards the partial entry in LOCKED.
- LOCKED  out  1  high in CAPTURE, LOCKED, CHECK, LOCKOUT.
- OPEN  out  1  high in IDLE.
- ALARM  out  1  high in LOCKOUT.
- ERR  out  1  one-cycle pulse on a failed attempt.
- FAIL_CNT  out  clog2(MAX_FAILS+1)  consecutive failures so far.
- ENTRY_CNT  out  clog2(DIGITS+1)  digits entered in the current attempt.

Behaviour:
- Reset (RST=1 at an edge, from any state):
  - state=IDLE, OPEN=1.
  - LOCKED=ALARM=ERR=0; FAIL_CNT=ENTRY_CNT=0.
  - Code registers, mismatch flag, capture index and timer cleared.
  - Reset mid-capture or mid-entry discards everything.
- IDLE: ARM=1 -> CAPTURE, cap_idx=0. KEY_VALID and CLEAR are ignored.
- CAPTURE:
  - Each cycle, code[cap_idx] <= LFSR_Q and cap_idx++.
  - After exactly DIGITS cycles -> LOCKED; code[0] is the value present in the first CAPTURE cycle.
  - ARM, KEY_VALID and CLEAR are ignored.
- LOCKED:
  - On KEY_VALID: mismatch <= mismatch | (KEY != code[ENTRY_CNT]); ENTRY_CNT++.
  - All DIGITS keys are always consumed; there is no early reject.
  - On the DIGITS-th key -> CHECK next cycle; ENTRY_CNT shows DIGITS during CHECK.
  - CLEAR=1: ENTRY_CNT=0, mismatch=0, FAIL_CNT unchanged. CLEAR and KEY_VALID in the same cycle: CLEAR wins and the key is dropped.
- CHECK (exactly one cycle). ENTRY_CNT and mismatch are cleared on exit. KEY_VALID is ignored.
  - No mismatch -> IDLE; FAIL_CNT=0; code retained but irrelevant, since re-arm recaptures it.
  - Mismatch -> ERR=1 for this cycle only; FAIL_CNT++.
  - If the new FAIL_CNT == MAX_FAILS -> LOCKOUT with timer=LOCKOUT_CYCLES; otherwise -> LOCKED.
- LOCKOUT:
  - ALARM=1; KEY_VALID and CLEAR ignored.
  - Timer decrements each cycle; when it reaches 1 -> LOCKED next edge, so ALARM is high for exactly LOCKOUT_CYCLES cycles.
  - On exit FAIL_CNT=0 and ENTRY_CNT=0; code unchanged.
- Outputs are registered: they change on the edge that changes state, so there are no combinational paths from inputs to outputs.
- Counter widths are sized so that neither counter wraps; FAIL_CNT saturates at MAX_FAILS by construction.
- Undefined state encodings return to IDLE.

Decomposition:
- Shared package lock_pkg:
  - State encoding constants IDLE, CAPTURE, LOCKED_S, CHECK, LOCKOUT.
  - Default WIDTH/DIGITS constants, shared with the LFSR bench.
  - clog2 helper function.
- Sub-module code_store:
  - DIGITS x WIDTH register file with write port (we, idx, data) and read port (idx -> data).
  - Clears on RST.
  - Instanced once; the FSM, counters and timer stay in code_lock_ctrl.

Test Plan (defaults; bench drives LFSR_Q directly):
- Capture + correct entry:
  - ARM for 1 cycle; LFSR_Q=05,0A,14,09 across 4 CAPTURE cycles; key 05,0A,14,09.
  - Expect: LOCKED=1 from cycle after 4th capture, CHECK 1 cycle, then OPEN=1, ERR never pulses, FAIL_CNT=0.
- Single wrong digit:
  - Same code; key 05,0A,15,09.
  - Expect: all 4 keys accepted, ERR pulse 1 cycle, FAIL_CNT=1, back to LOCKED, ENTRY_CNT=0.
- Lockout:
  - 3 wrong attempts.
  - Expect: FAIL_CNT=3 at entry to LOCKOUT, ALARM high exactly 8 cycles, keys during ALARM ignored, then LOCKED, FAIL_CNT=0.
  - Correct entry afterwards -> OPEN.
- CLEAR:
  - Key 05,0A; then CLEAR asserted together with KEY_VALID (KEY=14).
  - Expect: ENTRY_CNT=0, key dropped, FAIL_CNT unchanged; full correct entry then opens.
- Reset mid-operation:
  - RST asserted in CAPTURE cycle 2, and again in LOCKED after 2 keys.
  - Expect: next cycle OPEN=1, all counters 0; a re-arm recaptures a fresh code.
- Ignored inputs:
  - KEY_VALID in IDLE/CAPTURE and ARM in LOCKED.
  - Expect: no change to ENTRY_CNT or state.
